data_memory_responder: RTL and testbench
========================================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL define parameter DEPTH, default 256: number of 64-bit words; equals 2**8, fixed by the 8-bit address.
REQ-002 SHALL define parameter INIT_CLEAR, default 1: when 1, zero-fill the array after reset; when 0, go straight to READY.
REQ-003 Clock  input  1  single clock; all state changes on posedge.
REQ-004 Reset  input  1  synchronous, active-high.
REQ-005 Mem_Addr  input  [0:7]  word address from the processor, bit 0 = MSB.
REQ-006 Data_Out  input  [0:63]  store data from the processor.
REQ-007 DmemEn  input  1  access enable.
REQ-008 DmemWrEn  input  1  write qualifier; 1 = store, 0 = load; valid only with DmemEn=1.
REQ-009 Data_In  output  [0:63]  registered load data returned to the processor.
REQ-010 Init_Done  output  1  high once the array is ready for accesses.
REQ-011 Access_Err  output  1  sticky flag: an access arrived while not ready.

Function
REQ-012 SHALL hold a DEPTH x 64 storage array indexed by Mem_Addr, with bit 0 the MSB of each word.
REQ-013 SHALL implement FSM states CLEAR and READY.
REQ-014 CLEAR: 8-bit counter starts at 0; each cycle writes 64'h0 to mem[counter] and increments the counter.
REQ-015 CLEAR -> READY when the counter reaches 255, after writing word 255; CLEAR lasts exactly 256 cycles.
REQ-016 Init_Done SHALL be 0 in CLEAR and 1 in READY; READY is terminal until the next Reset.
REQ-017 Load in READY (DmemEn=1, DmemWrEn=0 sampled at edge N): Data_In = mem[Mem_Addr] from edge N, 1-cycle latency.
REQ-018 Store in READY (DmemEn=1, DmemWrEn=1 at edge N): mem[Mem_Addr] <= Data_Out at edge N; Data_In unchanged.
REQ-019 Load at edge N+1 to an address stored at edge N SHALL return the stored value.
REQ-020 Data_In SHALL hold the last load result through idle cycles and stores.
REQ-021 DmemEn=0 SHALL be a no-op regardless of DmemWrEn.
REQ-022 Any DmemEn=1 access in CLEAR SHALL be dropped: no write, and Data_In is forced to 64'h0.
REQ-023 Access_Err SHALL set on a dropped access and stay set until Reset.
REQ-024 Address range covers the full array; there is no out-of-range case and no wrap logic beyond the 8-bit counter.
REQ-025 No backpressure output exists; the responder SHALL accept one access every cycle in READY.

Reset
REQ-026 Reset=1 at an edge SHALL set Data_In=0, Access_Err=0, counter=0, and state=CLEAR (INIT_CLEAR=1) or READY (INIT_CLEAR=0).
REQ-027 Reset SHALL NOT clear the array directly; the contents are cleared only by the CLEAR sweep.
REQ-028 Reset asserted during CLEAR SHALL restart the sweep at word 0; Init_Done stays 0.
REQ-029 Reset asserted in READY SHALL drop any access in that cycle.

Verification
REQ-030 Release Reset, then count cycles with Init_Done=0 -> exactly 256 (INIT_CLEAR=1); with INIT_CLEAR=0, Init_Done=1 on the first cycle after release.
REQ-031 After Init_Done: store 0x0123456789ABCDEF to addr 0x05, then load addr 0x05 on the next cycle -> Data_In=0x0123456789ABCDEF one cycle after the load edge.
REQ-032 Back-to-back stores to 0x00 and 0xFF, then loads of both -> each returns its own data; idle cycles and a later store leave Data_In unchanged.
REQ-033 Load of an address never written after the CLEAR sweep -> 64'h0.
REQ-034 Store to 0x10 during CLEAR at cycle 10 -> Access_Err=1 on the next cycle; a load of 0x10 after READY returns 0.
REQ-035 Write 0xFFFF... to 0x20, assert Reset for 1 cycle in READY -> Access_Err=0, a full 256-cycle CLEAR follows, and a load of 0x20 returns 0.

Source files
------------

// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
//
// Single-port 256 x 64-bit data memory that answers processor loads and
// stores. After reset it optionally sweeps the whole array to zero (CLEAR)
// before it accepts accesses (READY). Any access that arrives during the
// sweep is dropped, and a sticky error flag records that it happened.
//
// Ports
//   Clock       in   single clock, all state changes on posedge
//   Reset       in   synchronous, active-high
//   Mem_Addr    in   [0:7]  word address (bit 0 = MSB)
//   Data_Out    in   [0:63] store data from the processor
//   DmemEn      in   access enable
//   DmemWrEn    in   1 = store, 0 = load (qualified by DmemEn)
//   Data_In     out  [0:63] registered load data, 1-cycle latency
//   Init_Done   out  high once the array is ready for accesses
//   Access_Err  out  sticky: an access arrived while not ready
// ---------------------------------------------------------------------------
module data_memory_responder #(
   parameter int DEPTH      = 256,
   parameter bit INIT_CLEAR = 1'b1
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [0:7]  Mem_Addr,
   input  logic [0:63] Data_Out,
   input  logic        DmemEn,
   input  logic        DmemWrEn,
   output logic [0:63] Data_In,
   output logic        Init_Done,
   output logic        Access_Err
);

   typedef enum logic {CLEAR, READY} state_t;

   state_t      state_reg;
   logic [7:0]  count_reg;
   logic        init_done_reg;
   logic        access_err_reg;
   logic [0:63] data_in_reg;

   logic [0:63] mem [DEPTH];

   logic        in_ready;
   logic        access;
   logic        store_en;
   logic        load_en;
   logic        drop;
   logic        clear_en;
   logic        mem_we;
   logic [7:0]  mem_waddr;
   logic [0:63] mem_wdata;

   // Accesses coinciding with Reset are ignored outright.
   assign in_ready = (state_reg == READY);
   assign access   = DmemEn && !Reset;
   assign store_en = access && in_ready && DmemWrEn;
   assign load_en  = access && in_ready && !DmemWrEn;
   assign drop     = access && !in_ready;
   assign clear_en = !Reset && !in_ready;

   // The sweep and processor stores never overlap, so one write port serves both.
   assign mem_we    = store_en || clear_en;
   assign mem_waddr = clear_en ? count_reg : Mem_Addr;
   assign mem_wdata = clear_en ? 64'h0 : Data_Out;

   // Storage array: no reset, so the contents only change through writes.
   always_ff @(posedge Clock) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Registered read port; holds its value except on loads and dropped accesses.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         data_in_reg <= 64'h0;
      end else if (drop) begin
         data_in_reg <= 64'h0;
      end else if (load_en) begin
         data_in_reg <= mem[Mem_Addr];
      end
   end

   // Control FSM: CLEAR sweeps words 0..255, then READY until the next Reset.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         count_reg      <= 8'd0;
         access_err_reg <= 1'b0;
         if (INIT_CLEAR) begin
            state_reg     <= CLEAR;
            init_done_reg <= 1'b0;
         end else begin
            state_reg     <= READY;
            init_done_reg <= 1'b1;
         end
      end else begin
         if (drop) begin
            access_err_reg <= 1'b1;
         end
         case (state_reg)
            CLEAR: begin
               count_reg <= count_reg + 8'd1;
               if (count_reg == 8'd255) begin
                  state_reg     <= READY;
                  init_done_reg <= 1'b1;
               end
            end
            READY: begin
               state_reg <= READY;
            end
            default: begin
               state_reg <= CLEAR;
            end
         endcase
      end
   end

   assign Data_In    = data_in_reg;
   assign Init_Done  = init_done_reg;
   assign Access_Err = access_err_reg;

endmodule

// File: tb/tb_data_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_data_memory_responder
//
// Directed test of data_memory_responder. A behavioural model tracks the
// expected memory image, load data, ready flag and error flag; a compare
// process checks all three outputs against it every cycle, and directed
// steps add hand-computed literal expectations. A second instance with
// INIT_CLEAR=0 shares the inputs to cover the no-sweep start-up.
// ---------------------------------------------------------------------------
module tb_data_memory_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        we;
   logic [0:7]  addr;
   logic [0:63] dout;
   logic [0:63] din;
   logic [0:63] din_nc;
   logic        done;
   logic        done_nc;
   logic        err;
   logic        err_nc;

   int   n_checks = 0;
   int   n_errs   = 0;
   logic chk_en   = 1'b0;
   int   cnt;

   always #5 clk = ~clk;

   data_memory_responder #(.DEPTH(256), .INIT_CLEAR(1'b1)) u_dut (
      .Clock      (clk),
      .Reset      (rst),
      .Mem_Addr   (addr),
      .Data_Out   (dout),
      .DmemEn     (en),
      .DmemWrEn   (we),
      .Data_In    (din),
      .Init_Done  (done),
      .Access_Err (err)
   );

   data_memory_responder #(.DEPTH(256), .INIT_CLEAR(1'b0)) u_nc (
      .Clock      (clk),
      .Reset      (rst),
      .Mem_Addr   (addr),
      .Data_Out   (dout),
      .DmemEn     (en),
      .DmemWrEn   (we),
      .Data_In    (din_nc),
      .Init_Done  (done_nc),
      .Access_Err (err_nc)
   );

   // Behavioural model: a reset arms a 256-cycle clear window; accesses in
   // the window are rejected; when it closes the whole image is zero.
   logic [0:63] m_mem [256];
   logic [0:63] m_data     = 64'h0;
   logic        m_err      = 1'b0;
   int          clear_left = 256;

   always @(posedge clk) begin
      if (rst) begin
         m_data     = 64'h0;
         m_err      = 1'b0;
         clear_left = 256;
      end else if (clear_left > 0) begin
         if (en) begin
            m_err  = 1'b1;
            m_data = 64'h0;
         end
         clear_left = clear_left - 1;
         if (clear_left == 0) begin
            for (int i = 0; i < 256; i++) m_mem[i] = 64'h0;
         end
      end else if (en) begin
         if (we) m_mem[addr] = dout;
         else    m_data = m_mem[addr];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_data_in", din, m_data);
         check("cyc_init_done", {63'd0, done}, {63'd0, clear_left == 0});
         check("cyc_access_err", {63'd0, err}, {63'd0, m_err});
      end
   end

   task automatic step(input logic e, input logic w, input logic [7:0] a, input logic [63:0] d);
      en   = e;
      we   = w;
      addr = a;
      dout = d;
      @(posedge clk);
      #1;
   endtask

   // Counts cycles with Init_Done low; optionally issues a store at cycle drop_at.
   task automatic count_clear(input int drop_at, output int n);
      n = 0;
      while (done == 1'b0 && n < 1000) begin
         n++;
         en   = (n == drop_at);
         we   = 1'b1;
         addr = 8'h10;
         dout = 64'hDEADBEEFCAFEF00D;
         @(posedge clk);
         #1;
         if (n == drop_at) check("err_after_drop", {63'd0, err}, 64'd1);
      end
      en = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      we   = 1'b0;
      addr = 8'h00;
      dout = 64'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_en = 1'b1;
      check("rst_data_in", din, 64'h0);
      check("rst_access_err", {63'd0, err}, 64'd0);
      check("rst_init_done", {63'd0, done}, 64'd0);
      check("nc_rst_init_done", {63'd0, done_nc}, 64'd1);
      rst = 1'b0;

      count_clear(10, cnt);
      $display("clear sweep: %0d cycles with Init_Done low", cnt);
      check("clear_cycles", cnt, 256);
      check("nc_init_done", {63'd0, done_nc}, 64'd1);
      check("nc_access_err", {63'd0, err_nc}, 64'd0);

      step(1, 1, 8'h05, 64'h0123456789ABCDEF);
      check("store_no_din_change", din, 64'h0);
      step(1, 0, 8'h05, 64'h0);
      $display("load 05 -> %h", din);
      check("load_05", din, 64'h0123456789ABCDEF);
      check("nc_load_05", din_nc, 64'h0123456789ABCDEF);
      step(1, 0, 8'h10, 64'h0);
      check("load_10_dropped", din, 64'h0);

      step(1, 1, 8'h00, 64'hA5A5A5A5A5A5A5A5);
      step(1, 1, 8'hFF, 64'h3C3C3C3C3C3C3C3C);
      step(1, 0, 8'h00, 64'h0);
      check("load_00", din, 64'hA5A5A5A5A5A5A5A5);
      step(1, 0, 8'hFF, 64'h0);
      check("load_ff", din, 64'h3C3C3C3C3C3C3C3C);
      step(0, 1, 8'h00, 64'h1111111111111111);
      step(0, 0, 8'hFF, 64'h0);
      check("idle_hold", din, 64'h3C3C3C3C3C3C3C3C);
      step(1, 1, 8'h33, 64'h7777777777777777);
      check("store_hold", din, 64'h3C3C3C3C3C3C3C3C);
      step(1, 0, 8'h77, 64'h0);
      check("load_unwritten", din, 64'h0);
      step(1, 0, 8'h00, 64'h0);
      check("en0_no_write", din, 64'hA5A5A5A5A5A5A5A5);
      step(1, 0, 8'h33, 64'h0);
      check("load_33", din, 64'h7777777777777777);

      step(1, 1, 8'h20, 64'hFFFFFFFFFFFFFFFF);
      step(1, 0, 8'h20, 64'h0);
      check("load_20", din, 64'hFFFFFFFFFFFFFFFF);
      rst = 1'b1;
      step(1, 1, 8'h21, 64'h5555555555555555);
      check("rst_clears_err", {63'd0, err}, 64'd0);
      check("rst_clears_din", din, 64'h0);
      check("rst_init_done_low", {63'd0, done}, 64'd0);
      rst = 1'b0;
      count_clear(0, cnt);
      $display("clear sweep after ready reset: %0d cycles", cnt);
      check("reclear_cycles", cnt, 256);
      step(1, 0, 8'h20, 64'h0);
      check("load_20_cleared", din, 64'h0);
      step(1, 0, 8'h21, 64'h0);
      check("load_21_cleared", din, 64'h0);

      step(1, 0, 8'h33, 64'h0);
      rst = 1'b1;
      step(0, 0, 8'h00, 64'h0);
      rst = 1'b0;
      repeat (50) step(0, 0, 8'h00, 64'h0);
      check("mid_clear_not_done", {63'd0, done}, 64'd0);
      rst = 1'b1;
      step(0, 0, 8'h00, 64'h0);
      rst = 1'b0;
      count_clear(0, cnt);
      $display("restarted clear sweep: %0d cycles", cnt);
      check("restart_clear_cycles", cnt, 256);
      step(1, 0, 8'h33, 64'h0);
      check("load_33_cleared", din, 64'h0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
